// File: rtl/mic_period_meter.sv
// Microphone period meter: a hysteresis comparator turns samples into rising edges, glitches are
// rejected, and accepted edge-to-edge distances are averaged, lock-checked and timeout-guarded.
module mic_period_meter #(
  parameter int unsigned             W_SAMPLE   = 16,
  parameter int unsigned             W_PERIOD   = 20,
  parameter logic [W_SAMPLE-1:0]     THRESHOLD  = 16'h1100,
  parameter logic [W_SAMPLE-1:0]     HYST       = 16'h0080,
  parameter int unsigned             MIN_PERIOD = 1000,
  parameter int unsigned             LOG2_AVG   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [W_SAMPLE-1:0] sample,
  output logic [W_PERIOD-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                timeout,
  output logic                dbg_comp_high
);

  // Handshake: sample is consumed on any clk edge where sample_valid=1 (no backpressure);
  // period is meaningful on the clk where period_valid=1 and holds its value otherwise.

  typedef enum logic {CMP_LOW = 1'b0, CMP_HIGH = 1'b1} cmp_state_t;

  localparam int unsigned         W_SUM   = W_PERIOD + LOG2_AVG;
  localparam logic [W_SAMPLE-1:0] LO      = THRESHOLD - HYST;
  localparam logic [W_PERIOD-1:0] MIN_CNT = W_PERIOD'(MIN_PERIOD);

  cmp_state_t          state;
  logic [W_PERIOD-1:0] cnt;
  logic                armed;
  logic                prev_ok;
  logic [W_SUM-1:0]    sum;
  logic [LOG2_AVG-1:0] n;

  logic                rise;
  logic                cnt_sat;
  logic [W_SUM-1:0]    sum_acc;
  logic [W_PERIOD-1:0] avg;
  logic [W_PERIOD-1:0] diff;
  logic                lock_ok;

  assign rise    = sample_valid && (state == CMP_LOW) && (sample >= THRESHOLD);
  assign cnt_sat = &cnt;
  assign sum_acc = sum + W_SUM'(cnt);
  assign avg     = sum_acc[W_SUM-1:LOG2_AVG];
  // Lock tolerance is relative to the previous average, which is still held in period.
  assign diff    = (avg >= period) ? (avg - period) : (period - avg);
  assign lock_ok = (diff <= (period >> 4));

  assign dbg_comp_high = (state == CMP_HIGH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CMP_LOW;
      cnt          <= '0;
      armed        <= 1'b0;
      prev_ok      <= 1'b0;
      sum          <= '0;
      n            <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;

      if (sample_valid) begin
        case (state)
          CMP_LOW:  if (sample >= THRESHOLD) state <= CMP_HIGH;
          CMP_HIGH: if (sample <= LO)        state <= CMP_LOW;
          default:                           state <= CMP_LOW;
        endcase
      end

      if (!cnt_sat) cnt <= cnt + W_PERIOD'(1);

      if (rise && (cnt_sat || !armed)) begin
        armed   <= 1'b1;
        cnt     <= W_PERIOD'(1);
        sum     <= '0;
        n       <= '0;
        timeout <= 1'b0;
      end else if (rise && (cnt >= MIN_CNT)) begin
        cnt <= W_PERIOD'(1);
        if (&n) begin
          period       <= avg;
          period_valid <= 1'b1;
          locked       <= prev_ok & lock_ok;
          prev_ok      <= 1'b1;
          sum          <= '0;
          n            <= '0;
        end else begin
          sum <= sum_acc;
          n   <= n + LOG2_AVG'(1);
        end
      end else if (cnt_sat) begin
        // Silence: drop lock history and require a fresh arming edge.
        timeout <= 1'b1;
        locked  <= 1'b0;
        prev_ok <= 1'b0;
        armed   <= 1'b0;
        sum     <= '0;
        n       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mic_period_meter.sv
// Bench for mic_period_meter: random waveforms checked each clk against a timestamp-based
// reference model, with a scoreboard queue of expected averaged periods.
module tb_mic_period_meter;

  localparam int          W_P     = 12;
  localparam int          MIN_P   = 50;
  localparam int          L2      = 2;
  localparam int          N_AVG   = 1 << L2;
  localparam logic [15:0] TH      = 16'h1100;
  localparam logic [15:0] HY      = 16'h0080;
  localparam logic [15:0] LO      = TH - HY;
  localparam int          CNT_MAX = (1 << W_P) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sample_valid = 1'b0;
  logic [15:0]    sample = '0;
  logic [W_P-1:0] period;
  logic           period_valid;
  logic           locked;
  logic           timeout;
  logic           dbg_comp_high;

  mic_period_meter #(
    .W_SAMPLE(16), .W_PERIOD(W_P), .THRESHOLD(TH), .HYST(HY),
    .MIN_PERIOD(MIN_P), .LOG2_AVG(L2)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .period(period), .period_valid(period_valid), .locked(locked), .timeout(timeout),
    .dbg_comp_high(dbg_comp_high)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  logic [W_P-1:0] exp_q[$];

  // reference model: event times, not counters
  bit m_high, m_armed, m_prev_ok, m_valid, m_locked, m_timeout;
  int m_period;
  int now_t, ref_t;
  int meas_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_high = 0; m_armed = 0; m_prev_ok = 0; m_valid = 0; m_locked = 0; m_timeout = 0;
    m_period = 0; now_t = 0; ref_t = 0;
    meas_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [15:0] s);
    int elapsed;
    bit rise;
    int sum;
    int avg;
    int diff;
    elapsed = now_t - ref_t;
    if (elapsed > CNT_MAX) elapsed = CNT_MAX;
    rise = v && !m_high && (s >= TH);
    if (v) begin
      if (s >= TH) m_high = 1;
      else if (s <= LO) m_high = 0;
    end
    m_valid = 0;
    if (rise && (elapsed == CNT_MAX || !m_armed)) begin
      m_armed = 1; ref_t = now_t; m_timeout = 0;
      meas_q.delete();
    end else if (rise && elapsed >= MIN_P) begin
      ref_t = now_t;
      meas_q.push_back(elapsed);
      if (meas_q.size() == N_AVG) begin
        sum = 0;
        foreach (meas_q[i]) sum += meas_q[i];
        avg  = sum / N_AVG;
        diff = (avg > m_period) ? avg - m_period : m_period - avg;
        m_locked  = m_prev_ok && (diff <= m_period / 16);
        m_prev_ok = 1;
        m_period  = avg;
        m_valid   = 1;
        exp_q.push_back(W_P'(avg));
        meas_q.delete();
      end
    end else if (elapsed == CNT_MAX) begin
      m_timeout = 1; m_locked = 0; m_prev_ok = 0; m_armed = 0;
      meas_q.delete();
    end
    now_t++;
  endtask

  // scoreboard / per-clk comparison
  task automatic check_outputs();
    logic [W_P-1:0] e;
    check_val("period", period, m_period);
    check_val("period_valid", period_valid, m_valid);
    check_val("locked", locked, m_locked);
    check_val("timeout", timeout, m_timeout);
    if (period_valid === 1'b1) begin
      check_val("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("sb_period", period, e);
      end
    end
  endtask

  // driver tasks
  task automatic step(input bit v, input logic [15:0] s);
    @(negedge clk);
    check_outputs();
    sample_valid = v;
    sample       = s;
    model_step(v, s);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    #1;
    model_reset();
    check_outputs();
    repeat (cycles) begin
      @(negedge clk);
      check_outputs();
    end
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    model_step(0, '0);
  endtask

  // mode 0: random levels, 1: plus early glitch spike, 2: hysteresis-band toggle, 3: clean square
  task automatic gen_period(input int len, input int hi_len, input int vpct, input int mode);
    bit v;
    logic [15:0] s;
    for (int i = 0; i < len; i++) begin
      v = ($urandom_range(99) < vpct);
      if (mode == 3)                        s = (i < hi_len) ? 16'h1400 : 16'h0E00;
      else if (i < hi_len)                  s = 16'($urandom_range(16'hFFFF, TH));
      else if (mode == 1 && (i == 20 || i == 21)) s = 16'h1400;
      else if (mode == 2 && i < len - 20)   s = (i % 2 == 1) ? 16'h1090 : 16'h1100;
      else if ($urandom_range(99) < 5)      s = 16'($urandom_range(16'h10FF, 16'h1081));
      else                                  s = 16'($urandom_range(LO, 0));
      step(v, s);
    end
  endtask

  initial begin
    model_reset();
    do_reset(5);
    check_val("rst_period", period, 0);
    check_val("rst_locked", locked, 0);

    // steady square: arm, first average, then lock
    repeat (5) gen_period(200, 100, 100, 3);
    check_val("sq_first_avg", period, 200);
    check_val("sq_first_unlocked", locked, 0);
    repeat (4) gen_period(200, 100, 100, 3);
    check_val("sq_second_avg", period, 200);
    check_val("sq_locked", locked, 1);

    // glitch spikes shortly after each accepted edge
    repeat (4) gen_period(200, 10, 100, 1);
    gen_period(200, 100, 100, 3);
    check_val("glitch_avg", period, 200);

    // toggling just inside the hysteresis band yields no extra edges
    repeat (4) gen_period(200, 10, 100, 2);
    gen_period(200, 100, 100, 3);
    check_val("hyst_avg", period, 200);

    // random periods, valid gaps, noise, spikes
    repeat (30) gen_period($urandom_range(300, 40), $urandom_range(30, 5),
                           $urandom_range(100, 70), $urandom_range(1, 0));
    repeat (12) gen_period($urandom_range(205, 195), 20, 100, 0);

    // MIN_PERIOD boundary: exactly MIN accepted, one less rejected
    repeat (8) gen_period(MIN_P, 10, 100, 3);
    repeat (8) gen_period(MIN_P - 1, 10, 100, 3);

    // silence timeout after lock
    repeat (9) gen_period(200, 100, 100, 3);
    repeat (CNT_MAX + 100) step(1, 16'h0E00);
    check_val("to_timeout", timeout, 1);
    check_val("to_unlocked", locked, 0);
    gen_period(200, 100, 100, 3);
    check_val("to_cleared", timeout, 0);
    repeat (5) gen_period(200, 100, 100, 3);

    // rise in the very cycle the counter saturates
    gen_period(CNT_MAX, 10, 100, 3);
    gen_period(CNT_MAX, 10, 100, 3);
    check_val("sat_rise_no_timeout", timeout, 0);

    // reset mid-average
    repeat (3) gen_period(200, 100, 100, 3);
    repeat (50) step(1, 16'h0E00);
    do_reset(3);
    repeat (6) gen_period(200, 100, 100, 3);
    check_val("post_rst_avg", period, 200);
    check_val("post_rst_unlocked", locked, 0);

    step(0, '0);
    check_val("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
